// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
// Owner encoding is 3 bits so the response register stays a plain enum.
package imem_arb_pkg;

  typedef enum logic [2:0] {
    RESP_NONE      = 3'd0,
    RESP_FETCH     = 3'd1,
    RESP_LOAD      = 3'd2,
    RESP_ERR_FETCH = 3'd3,
    RESP_ERR_LOAD  = 3'd4
  } owner_e;

  localparam logic [31:0] ERR_RDATA = 32'h0;

  // Word-aligned and the whole word fits inside the memory.
  function automatic logic addr_legal(input logic [63:0] addr,
                                      input logic [63:0] depth_bytes);
    return (addr[1:0] == 2'b00) &&
           (depth_bytes >= 64'd4) &&
           (addr <= depth_bytes - 64'd4);
  endfunction

endpackage

// File: rtl/imem_arb_resp.sv
// Response owner register and routing of the one-cycle memory response
// (or a synthesized error) back to whichever requester was granted.
module imem_arb_resp
  import imem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  owner_e      owner_d,
  input  logic        load_we_d,
  input  logic [31:0] m_rdata,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        l_err
);

  owner_e owner_q;
  logic   load_we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= RESP_NONE;
      load_we_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      load_we_q <= load_we_d;
    end
  end

  always_comb begin
    f_rvalid = 1'b0;
    f_rdata  = ERR_RDATA;
    f_err    = 1'b0;
    l_rvalid = 1'b0;
    l_rdata  = ERR_RDATA;
    l_err    = 1'b0;
    case (owner_q)
      RESP_FETCH: begin
        f_rvalid = 1'b1;
        f_rdata  = m_rdata;
      end
      RESP_LOAD: begin
        // Write acks carry no data; only reads forward the memory word.
        l_rvalid = 1'b1;
        l_rdata  = load_we_q ? 32'h0 : m_rdata;
      end
      RESP_ERR_FETCH: begin
        f_rvalid = 1'b1;
        f_err    = 1'b1;
      end
      RESP_ERR_LOAD: begin
        l_rvalid = 1'b1;
        l_err    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter: loader has priority, fetch is
// guaranteed a slot after STARVE_LIMIT consecutive loader grants.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DEPTH_BYTES  = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              l_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int          SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [63:0] DEPTH64    = 64'(DEPTH_BYTES);

  logic [SW-1:0] starve_q, starve_d;
  logic          f_legal, l_legal;
  logic          fetch_wins, grant_f, grant_l;
  owner_e        owner_d;
  logic          load_we_d;

  always_comb begin
    f_legal    = addr_legal(64'(f_addr), DEPTH64);
    l_legal    = addr_legal(64'(l_addr), DEPTH64);
    fetch_wins = f_req && (!l_req || (starve_q == STARVE_MAX));
    // Grants are held off during reset so nothing reaches memory.
    grant_f    = !rst && fetch_wins;
    grant_l    = !rst && l_req && !fetch_wins;
  end

  always_comb begin
    owner_d   = RESP_NONE;
    load_we_d = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    if (grant_f) begin
      owner_d = f_legal ? RESP_FETCH : RESP_ERR_FETCH;
      if (f_legal) begin
        m_en   = 1'b1;
        m_addr = f_addr;
      end
    end else if (grant_l) begin
      owner_d   = l_legal ? RESP_LOAD : RESP_ERR_LOAD;
      load_we_d = l_we;
      if (l_legal) begin
        m_en    = 1'b1;
        m_we    = l_we;
        m_addr  = l_addr;
        m_wdata = l_wdata;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!f_req || grant_f) begin
      starve_d = '0;
    end else if (grant_l && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign f_gnt = grant_f;
  assign l_gnt = grant_l;

  imem_arb_resp u_resp (
    .clk      (clk),
    .rst      (rst),
    .owner_d  (owner_d),
    .load_we_d(load_we_d),
    .m_rdata  (m_rdata),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .f_err    (f_err),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .l_err    (l_err)
  );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small word memory model
// answering one cycle after m_en.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, f_err;
  logic [31:0] f_rdata;
  logic        l_gnt, l_rvalid, l_err;
  logic [31:0] l_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [64];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(32), .DEPTH_BYTES(256), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata (f_rdata),
    .f_err   (f_err),
    .l_req   (l_req),
    .l_we    (l_we),
    .l_addr  (l_addr),
    .l_wdata (l_wdata),
    .l_gnt   (l_gnt),
    .l_rvalid(l_rvalid),
    .l_rdata (l_rdata),
    .l_err   (l_err),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[7:2]] <= m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0; f_addr = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
  endtask

  initial begin
    bit [9:0] f_pat;
    bit       prev_f;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h00A00093;
    mem[63] = 32'h12345678;
    m_rdata = 32'h0;
    idle();
    rst = 1'b1;
    step();
    step();
    check("rst_f_rvalid", {31'b0, f_rvalid}, 32'd0);
    check("rst_l_rvalid", {31'b0, l_rvalid}, 32'd0);
    check("rst_m_en", {31'b0, m_en}, 32'd0);
    check("rst_m_addr", m_addr, 32'h0);
    rst = 1'b0;

    // Fetch of a legal word.
    f_req = 1'b1; f_addr = 32'h10;
    #1;
    $display("txn fetch addr=%h", f_addr);
    check("t1_f_gnt", {31'b0, f_gnt}, 32'd1);
    check("t1_m_en", {31'b0, m_en}, 32'd1);
    check("t1_m_we", {31'b0, m_we}, 32'd0);
    check("t1_m_addr", m_addr, 32'h10);
    step();
    idle();
    #1;
    check("t1_f_rvalid", {31'b0, f_rvalid}, 32'd1);
    check("t1_f_rdata", f_rdata, 32'h00A00093);
    check("t1_f_err", {31'b0, f_err}, 32'd0);

    // Loader write beats waiting fetch; then fetch reads the new word.
    f_req = 1'b1; f_addr = 32'h8;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_wdata = 32'hDEADBEEF;
    #1;
    $display("txn loader write addr=%h data=%h (fetch pending)", l_addr, l_wdata);
    check("t2_l_gnt", {31'b0, l_gnt}, 32'd1);
    check("t2_f_gnt", {31'b0, f_gnt}, 32'd0);
    check("t2_m_we", {31'b0, m_we}, 32'd1);
    check("t2_m_wdata", m_wdata, 32'hDEADBEEF);
    step();
    l_req = 1'b0; l_we = 1'b0;
    #1;
    check("t2_l_rvalid", {31'b0, l_rvalid}, 32'd1);
    check("t2_l_err", {31'b0, l_err}, 32'd0);
    check("t2_l_rdata", l_rdata, 32'h0);
    check("t2_f_rvalid", {31'b0, f_rvalid}, 32'd0);
    check("t2_f_gnt_next", {31'b0, f_gnt}, 32'd1);
    $display("txn fetch addr=%h after write", f_addr);
    step();
    idle();
    #1;
    check("t2_f_rdata_new", f_rdata, 32'hDEADBEEF);

    // Loader streams with fetch continuously waiting: L L L L F L L L L F.
    f_pat = 10'b1000010000;
    prev_f = 1'b0;
    f_req = 1'b1; f_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h40 + 32'(4 * i); l_wdata = 32'(i);
      #1;
      $display("txn stream %0d f_gnt=%0b l_gnt=%0b", i, f_gnt, l_gnt);
      check($sformatf("t3_f_gnt_%0d", i), {31'b0, f_gnt}, {31'b0, f_pat[i]});
      check($sformatf("t3_l_gnt_%0d", i), {31'b0, l_gnt}, {31'b0, !f_pat[i]});
      if (i > 0) check($sformatf("t3_f_rvalid_%0d", i), {31'b0, f_rvalid}, {31'b0, prev_f});
      prev_f = f_pat[i];
      step();
    end
    idle();
    #1;
    check("t3_last_f_rvalid", {31'b0, f_rvalid}, 32'd1);

    // Misaligned fetch.
    f_req = 1'b1; f_addr = 32'h2;
    #1;
    $display("txn fetch misaligned addr=%h", f_addr);
    check("t4_f_gnt", {31'b0, f_gnt}, 32'd1);
    check("t4_f_m_en", {31'b0, m_en}, 32'd0);
    step();
    idle();
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h100;
    #1;
    check("t4_f_err", {31'b0, f_err}, 32'd1);
    check("t4_f_rvalid", {31'b0, f_rvalid}, 32'd1);
    check("t4_f_rdata", f_rdata, 32'h0);
    $display("txn loader read out-of-range addr=%h", l_addr);
    check("t4_l_gnt", {31'b0, l_gnt}, 32'd1);
    check("t4_l_m_en", {31'b0, m_en}, 32'd0);
    step();
    l_addr = 32'hFC;
    #1;
    check("t4_l_err", {31'b0, l_err}, 32'd1);
    check("t4_l_rdata", l_rdata, 32'h0);
    check("t4_f_err_clear", {31'b0, f_err}, 32'd0);
    $display("txn loader read last word addr=%h", l_addr);
    check("t4_edge_m_en", {31'b0, m_en}, 32'd1);
    step();
    l_we = 1'b1; l_addr = 32'h101; l_wdata = 32'hCAFEF00D;
    #1;
    check("t4_edge_l_rdata", l_rdata, 32'h12345678);
    check("t4_edge_l_err", {31'b0, l_err}, 32'd0);
    $display("txn loader write illegal addr=%h", l_addr);
    check("t4_wr_m_en", {31'b0, m_en}, 32'd0);
    check("t4_wr_m_we", {31'b0, m_we}, 32'd0);
    step();
    idle();
    #1;
    check("t4_wr_l_rvalid", {31'b0, l_rvalid}, 32'd1);
    check("t4_wr_l_err", {31'b0, l_err}, 32'd1);
    step();

    // Reset right after a fetch grant.
    f_req = 1'b1; f_addr = 32'h10;
    #1;
    $display("txn fetch addr=%h then reset", f_addr);
    check("t5_f_gnt", {31'b0, f_gnt}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("t5_gnt_in_rst", {31'b0, f_gnt}, 32'd0);
    step();
    check("t5_f_rvalid", {31'b0, f_rvalid}, 32'd0);
    check("t5_f_rdata", f_rdata, 32'h0);
    check("t5_f_err", {31'b0, f_err}, 32'd0);
    check("t5_m_en", {31'b0, m_en}, 32'd0);
    check("t5_m_addr", m_addr, 32'h0);
    rst = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitrates single-ported access to the byte-addressed instruction memory between the core fetch stage and the boot/debug loader. Grants one request per cycle, drives the memory's enable/write/address/data, and routes the one-cycle-latency memory response back to the granted requester. Unaligned and out-of-range accesses never reach the memory; they complete with an error response. A starvation counter guarantees fetch progress while the loader streams.

## Interface
- ADDR_W, 32, byte-address width
- DEPTH_BYTES, 256, memory size in bytes; legal word addresses are 0..DEPTH_BYTES-4
- STARVE_LIMIT, 4, consecutive loader grants allowed while fetch waits (min 1)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request, read only
- f_addr  in  ADDR_W  fetch byte address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch response valid
- f_rdata  out  32  fetch instruction word, little-endian
- f_err  out  1  fetch response is an error
- l_req  in  1  loader request
- l_we  in  1  1 = write word, 0 = read word
- l_addr  in  ADDR_W  loader byte address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader granted this cycle
- l_rvalid  out  1  loader response/ack valid
- l_rdata  out  32  loader read data
- l_err  out  1  loader response is an error
- m_en  out  1  memory access strobe
- m_we  out  1  memory write strobe
- m_addr  out  ADDR_W  memory byte address
- m_wdata  out  32  memory write word
- m_rdata  in  32  memory read word, valid cycle after m_en

## Operation
- Request held by requester until its gnt; gnt is combinational from req, addresses and registered state.
- Priority: loader over fetch, except when starve_cnt == STARVE_LIMIT and f_req=1, then fetch wins.
- starve_cnt: +1 on each loader grant while f_req=1; cleared on any fetch grant or any cycle with f_req=0; saturates at STARVE_LIMIT.
- Legality: addr[1:0]==0 and addr <= DEPTH_BYTES-4. Illegal granted request: m_en=0, error response next cycle.
- Legal granted request: m_en=1, m_we=l_we for loader (0 for fetch), m_addr=addr, m_wdata=l_wdata.
- No grant: m_en=0, m_we=0, m_addr/m_wdata=0.
- Owner register (FSM): RESP_NONE, RESP_FETCH, RESP_LOAD, RESP_ERR_FETCH, RESP_ERR_LOAD; loaded every cycle from the grant decision.
- Response (owner state): RESP_FETCH -> f_rvalid=1, f_rdata=m_rdata; RESP_LOAD -> l_rvalid=1, l_rdata=m_rdata for reads, 0 for writes; RESP_ERR_* -> rvalid=1, err=1, rdata=0. Non-owner rdata outputs are 0.
- Writes also return l_rvalid ack with l_err=0 (legal) or 1 (illegal).

## Timing
- Grant to response: exactly 1 cycle; throughput one access per cycle, back-to-back grants allowed.
- Reset values: owner=RESP_NONE, starve_cnt=0; all gnt, rvalid, err, m_en, m_we = 0; all data/address outputs = 0.
- rst in cycle after grant: response suppressed, rvalid stays 0; in-flight write to memory already issued is not undone.
- Simultaneous f_req and l_req: exactly one gnt high; never both.
- Loader write then fetch of same address next cycle: fetch sees new data (memory write-first not required; ordering by grant sequence only).
- rvalid, err and owner change only on clk rising edge.

## Structure
- Package imem_arb_pkg: owner state encoding (3 bits), ERR_RDATA = 32'h0, legality helper function.
- One sub-module natural: imem_arb_resp (owner register plus response mux to f_/l_ ports); arbitration and starve counter stay in top.

## Test plan
- Fetch only, f_addr=0x10, m_rdata=0x00A00093 -> f_gnt same cycle, m_addr=0x10, next cycle f_rvalid=1, f_rdata=0x00A00093, f_err=0.
- Loader write 0x8 = 0xDEADBEEF with f_req high -> l_gnt=1, f_gnt=0, m_we=1, m_wdata=0xDEADBEEF; next cycle l_rvalid=1, l_err=0, f_rvalid=0.
- Loader streams writes 6 cycles, f_req continuous, STARVE_LIMIT=4 -> grants L,L,L,L,F,L; starve_cnt returns to 0 after fetch grant.
- Fetch f_addr=0x02 and loader l_addr=0x100 (DEPTH_BYTES=256) -> m_en=0 for each; next cycle err=1, rdata=0.
- rst asserted cycle after fetch grant -> f_rvalid=0, all outputs at reset values following edge.
